// File: rtl/seq_calculator.sv
// Sequential four-function calculator with BCD conversion and 7-segment display drive.
//
// An operation is captured on a start strobe and run over several cycles: add and sub
// take one cycle, multiply uses shift-add and divide uses restoring division. The
// binary result is then converted to BCD by double-dabble and shown on DIGITS
// active-low 7-segment digits plus a sign digit.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   start       one-cycle request, only sampled while idle
//   op          00 add, 01 sub, 10 mul, 11 div
//   a, b        WIDTH-bit unsigned operands
//   busy        operation in progress
//   done        one-cycle completion pulse; result/bcd/neg/err update with it
//   result      unsigned result magnitude (2*WIDTH bits)
//   neg         result is negative (sub only)
//   err         divide by zero
//   bcd         BCD of result, digit 0 in [3:0]
//   seg         active-low segments, digit i in [7i+6:7i], bit0 = a .. bit6 = g
//   sign_seg    active-low sign digit
//
// DIGITS must satisfy 10^DIGITS > (2^WIDTH-1)^2 so the largest product fits.

module seq_calculator #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  neg,
    output logic                  err,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            sign_seg
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(RW + 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegMinus = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StCalc, StConv, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    // hi/lo: partial product and multiplier for mul, remainder and quotient for div
    logic [WIDTH:0]    hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     bin_q, bin_d;
    logic [BW-1:0]     dd_q, dd_d;
    logic [RW-1:0]     res_q, res_d;
    logic              neg_p_q, neg_p_d;
    logic              err_p_q, err_p_d;
    logic [RW-1:0]     result_q, result_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Single-step datapath results
    logic [WIDTH:0]    add_sum;
    logic              a_ge_b;
    logic [WIDTH-1:0]  sub_diff;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    mul_hi_nx;
    logic [WIDTH-1:0]  mul_lo_nx;
    logic [WIDTH:0]    div_rs;
    logic              div_ge;
    logic [WIDTH:0]    div_hi_nx;
    logic [WIDTH-1:0]  div_lo_nx;
    logic [BW-1:0]     dd_adj;
    logic [RW-1:0]     calc_val;
    logic              load_conv;

    always_comb begin
        add_sum   = {1'b0, opa_q} + {1'b0, opb_q};
        a_ge_b    = opa_q >= opb_q;
        sub_diff  = a_ge_b ? (opa_q - opb_q) : (opb_q - opa_q);

        // Add multiplicand to the upper half when the multiplier LSB is set, then shift right
        mul_sum   = {1'b0, hi_q[WIDTH-1:0]} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_hi_nx = {1'b0, mul_sum[WIDTH:1]};
        mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and subtract if it fits
        div_rs    = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_ge    = div_rs >= {1'b0, opb_q};
        div_hi_nx = div_ge ? (div_rs - {1'b0, opb_q}) : div_rs;
        div_lo_nx = {lo_q[WIDTH-2:0], div_ge};

        dd_adj = dd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dd_q[4*i +: 4] >= 4'd5) begin
                dd_adj[4*i +: 4] = dd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        dd_d      = dd_q;
        res_d     = res_q;
        neg_p_d   = neg_p_q;
        err_p_d   = err_p_q;
        result_d  = result_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        err_d     = err_q;
        done_d    = 1'b0;
        // Registered, so it rises one cycle after acceptance and drops as done rises
        busy_d    = (state_q == StCalc) || (state_q == StConv);
        calc_val  = '0;
        load_conv = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    opa_d   = a;
                    opb_d   = b;
                    hi_d    = '0;
                    lo_d    = a;
                    cnt_d   = '0;
                    neg_p_d = 1'b0;
                    err_p_d = 1'b0;
                    state_d = StCalc;
                end
            end

            StCalc: begin
                unique case (op_q)
                    2'b00: begin
                        calc_val  = {{(WIDTH-1){1'b0}}, add_sum};
                        load_conv = 1'b1;
                    end
                    2'b01: begin
                        calc_val  = {{WIDTH{1'b0}}, sub_diff};
                        neg_p_d   = ~a_ge_b;
                        load_conv = 1'b1;
                    end
                    2'b10: begin
                        hi_d  = mul_hi_nx;
                        lo_d  = mul_lo_nx;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            calc_val  = {mul_hi_nx[WIDTH-1:0], mul_lo_nx};
                            load_conv = 1'b1;
                        end
                    end
                    2'b11: begin
                        if (opb_q == '0) begin
                            err_p_d   = 1'b1;
                            calc_val  = '0;
                            load_conv = 1'b1;
                        end else begin
                            hi_d  = div_hi_nx;
                            lo_d  = div_lo_nx;
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == CW'(WIDTH - 1)) begin
                                calc_val  = {{WIDTH{1'b0}}, div_lo_nx};
                                load_conv = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase

                if (load_conv) begin
                    res_d   = calc_val;
                    bin_d   = calc_val;
                    dd_d    = '0;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end

            StConv: begin
                dd_d  = {dd_adj[BW-2:0], bin_q[RW-1]};
                bin_d = {bin_q[RW-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RW - 1)) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                result_d = res_q;
                bcd_d    = dd_q;
                neg_d    = neg_p_q;
                err_d    = err_p_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            dd_q     <= '0;
            res_q    <= '0;
            neg_p_q  <= 1'b0;
            err_p_q  <= 1'b0;
            result_q <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            dd_q     <= dd_d;
            res_q    <= res_d;
            neg_p_q  <= neg_p_d;
            err_p_q  <= err_p_d;
            result_q <= result_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Leading-zero blanking: scan from the top digit, show once a nonzero digit is seen
    always_comb begin
        logic seen;
        seen = 1'b0;
        seg  = {(7*DIGITS){1'b1}};
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (err_q) begin
                seg[7*i +: 7] = SegMinus;
            end else if (seen || (i == 0)) begin
                seg[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
            end else begin
                seg[7*i +: 7] = SegBlank;
            end
        end
        sign_seg = (neg_q && !err_q) ? SegMinus : SegBlank;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign neg    = neg_q;
    assign err    = err_q;
    assign bcd    = bcd_q;

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, clocked successor to the switch-driven four-function calculator.
- Operands of WIDTH bits are latched on a start strobe and the operation runs multi-cycle: shift-add multiply, restoring divide.
- The binary result is converted to BCD by sequential double-dabble and drives DIGITS active-low 7-segment digits plus a sign digit.
- Sits between the board switch/key debouncers and the HEX displays.

Parameters:
- WIDTH, 4, operand width in bits (2..8).
- DIGITS, 3, decimal display digits. Must satisfy 10^DIGITS > (2^WIDTH-1)^2; the default covers 225.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- a  in  WIDTH  operand 1.
- b  in  WIDTH  operand 2.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.
- result  out  2*WIDTH  magnitude of the result, unsigned.
- neg  out  1  result negative (sub only).
- err  out  1  divide by zero.
- bcd  out  4*DIGITS  BCD of result; digit 0 in [3:0].
- seg  out  7*DIGITS  active-low segments, digit i in [7i+6:7i], bit0=a .. bit6=g.
- sign_seg  out  7  active-low sign digit.

Behaviour:
- Reset: asynchronous on rst_n=0. State=IDLE; busy, done, neg, err = 0; result and bcd = 0. Display shows "0" in digit 0, other digits and sign_seg blank (7'h7F). Reset mid-operation aborts immediately; no done pulse.
- FSM states are IDLE, CALC, CONV, DONE.
- IDLE: start=1 latches a, b, op and goes to CALC. start is ignored in every other state, and a/b/op changes during busy are ignored.
- CALC, add: 1 cycle, result a+b.
- CALC, sub: 1 cycle. If a>=b, result a-b and neg=0; otherwise result b-a and neg=1. 0 is never negative.
- CALC, mul: WIDTH cycles, shift-add, 2*WIDTH-bit product.
- CALC, div:
  - b=0: 1 cycle, err=1, result=0.
  - Otherwise: WIDTH cycles restoring division, result = floor(a/b) zero-extended. The remainder is discarded.
- CONV: exactly 2*WIDTH cycles of double-dabble (add 3 to any nibble >=5, then shift). It runs even for err or 0.
- DONE: 1 cycle. result, bcd, neg, err are registered together, done=1, busy=0 in this cycle. Next state is IDLE.
- Latency: done is high on the cycle C+2*WIDTH+1 edges after the start-sampling edge, where C = 1 (add, sub, div-by-0) or WIDTH (mul, div). WIDTH=4: add 10, mul 13.
- Outputs hold their previous values while busy; they change only on entry to DONE.
- Display, combinational from the registered bcd/neg/err:
  - Standard active-low 0-9 patterns; "1" = 7'b1111001, "6" = 7'b0000010.
  - Leading-zero blanking: digits above the most significant nonzero digit are 7'h7F. Digit 0 is always shown.
  - sign_seg = 7'b0111111 (minus) when neg=1, else 7'h7F.
  - When err=1, every seg digit = 7'b0111111 and sign_seg is blank.
- A new start accepted in the IDLE cycle after DONE is legal (back-to-back operation).

Test Plan:
- WIDTH=4, add, a=9, b=7, start → done 10 edges later; result=16, bcd=12'h016, seg[6:0]=7'b0000010, seg[13:7]=7'b1111001, hundreds blank, neg=0.
- sub, a=3, b=12 → result=9, neg=1, sign_seg=7'b0111111, tens and hundreds blank; then sub a=5, b=5 → result=0, neg=0, units "0".
- mul, a=15, b=15 → done 13 edges after start, result=225, bcd=12'h225; busy high for exactly 12 cycles.
- div, a=13, b=0 → err=1, result=0, all seg digits 7'b0111111; then div a=13, b=4 → err=0, result=3.
- Pulse start again at cycles 3 and 6 of a mul with different operands → ignored; the original result is delivered. Back-to-back start on the cycle after done → accepted.
- Assert rst_n=0 during CONV of a mul → busy=0 immediately, no done pulse, result=0, display "0"; a later add 1+1 completes with result=2.
